leve1_id: RTL and testbench

// - Decode/operand stage directly upstream of the EX stage.
// - Accepts fetched instructions over a valid/ready handshake and holds the 32x`XLEN GPR file.
// - Reads rs1/rs2 with bypass from EX (FWD_RD) and from writeback (WB_RD).
// - Presents a registered ID_VALID/ID_PC/ID_INSTR/ID_RS1/ID_RS2 bundle to EX.
// - Serialises SYSTEM instructions so CSR reads see the previous CSR write.

---
 rtl/leve1_id.sv | 165 ++++++++++++++++
 tb/tb_leve1_id.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/leve1_id.sv
// Decode/operand stage feeding EX: GPR file, rs1/rs2 bypass, registered EX bundle, SYSTEM serialisation.
// Optional feature: define LEVE_ID_BYPASS_EN to enable the EX-result bypass (otherwise RAW hazards stall one cycle).
`ifndef XLEN
`define XLEN 32
`endif

module leve1_id #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              IF_VALID,
    output logic              IF_READY,
    input  logic [`XLEN-1:0]  IF_PC,
    input  logic [31:0]       IF_INSTR,
    input  logic              FLUSH,
    input  logic [`XLEN-1:0]  FWD_RD,
    input  logic              WB_VALID,
    input  logic              WB_WE,
    input  logic [31:0]       WB_INSTR,
    input  logic [`XLEN-1:0]  WB_RD,
    output logic              ID_VALID,
    output logic [`XLEN-1:0]  ID_PC,
    output logic [31:0]       ID_INSTR,
    output logic [`XLEN-1:0]  ID_RS1,
    output logic [`XLEN-1:0]  ID_RS2
);

    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [1:0] {RUN, SER1, SER2} state_t;

    state_t             state_q, state_d;
    logic               id_valid_q, id_valid_d;
    logic [`XLEN-1:0]   id_pc_q, id_pc_d;
    logic [31:0]        id_instr_q, id_instr_d;
    logic [`XLEN-1:0]   id_rs1_q, id_rs1_d;
    logic [`XLEN-1:0]   id_rs2_q, id_rs2_d;
    logic [`XLEN-1:0]   gpr_q [32];

    logic [4:0]         rs1_idx, rs2_idx, id_rd, wb_rd_idx;
    logic [6:0]         id_opc;
    logic               id_writer_op, id_writer, wb_hit_en, gpr_we;
    logic               raw_stall, cap;

    assign rs1_idx   = IF_INSTR[19:15];
    assign rs2_idx   = IF_INSTR[24:20];
    assign id_rd     = id_instr_q[11:7];
    assign id_opc    = id_instr_q[6:0];
    assign wb_rd_idx = WB_INSTR[11:7];

    // A CSR instruction only writes rd when funct3 is non-zero (ECALL/EBREAK/xRET do not).
    always_comb begin
        id_writer_op = 1'b0;
        case (id_opc)
            OPC_OP_IMM, OPC_OP_IMM_32, OPC_OP, OPC_LUI, OPC_AUIPC: id_writer_op = 1'b1;
            OPC_SYSTEM: id_writer_op = (id_instr_q[14:12] != 3'b000);
            default:    id_writer_op = 1'b0;
        endcase
    end

    assign id_writer = id_valid_q & (id_rd != 5'd0) & id_writer_op;
    assign wb_hit_en = WB_VALID & WB_WE;
    assign gpr_we    = wb_hit_en & (wb_rd_idx != 5'd0);

    // Priority: x0, younger EX result (bypass builds only), writeback data, register file.
    function automatic logic [`XLEN-1:0] pick_operand(
        input logic [4:0]        idx,
        input logic [`XLEN-1:0]  gpr_val
    );
        logic [`XLEN-1:0] val;
        val = gpr_val;
        if (idx == 5'd0)
            val = '0;
`ifdef LEVE_ID_BYPASS_EN
        else if (id_writer && (id_rd == idx))
            val = FWD_RD;
`endif
        else if (wb_hit_en && (wb_rd_idx == idx))
            val = WB_RD;
        return val;
    endfunction

`ifdef LEVE_ID_BYPASS_EN
    assign raw_stall = 1'b0;
`else
    assign raw_stall = id_writer & ((id_rd == rs1_idx) | (id_rd == rs2_idx));
`endif

    assign IF_READY = (state_q == RUN) & ~raw_stall;
    assign cap      = IF_VALID & IF_READY & ~FLUSH;

    always_comb begin
        id_valid_d = cap;
        id_pc_d    = id_pc_q;
        id_instr_d = NOP_INSTR;
        id_rs1_d   = id_rs1_q;
        id_rs2_d   = id_rs2_q;
        if (cap) begin
            id_pc_d    = IF_PC;
            id_instr_d = IF_INSTR;
            id_rs1_d   = pick_operand(rs1_idx, gpr_q[rs1_idx]);
            id_rs2_d   = pick_operand(rs2_idx, gpr_q[rs2_idx]);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (cap && (IF_INSTR[6:0] == OPC_SYSTEM)) state_d = SER1;
            SER1:    state_d = SER2;
            SER2:    state_d = RUN;
            default: state_d = RUN;
        endcase
        if (FLUSH)
            state_d = RUN;
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q    <= RUN;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_instr_q <= NOP_INSTR;
            id_rs1_q   <= '0;
            id_rs2_q   <= '0;
        end else begin
            state_q    <= state_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
            id_rs1_q   <= id_rs1_d;
            id_rs2_q   <= id_rs2_d;
        end
    end

    // x0 is never written, so its entry stays at the reset value of zero.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            for (int i = 0; i < 32; i++)
                gpr_q[i] <= '0;
        end else if (gpr_we) begin
            gpr_q[wb_rd_idx] <= WB_RD;
        end
    end

    assign ID_VALID = id_valid_q;
    assign ID_PC    = id_pc_q;
    assign ID_INSTR = id_instr_q;
    assign ID_RS1   = id_rs1_q;
    assign ID_RS2   = id_rs2_q;

    logic unused_bits;
`ifdef LEVE_ID_BYPASS_EN
    assign unused_bits = ^{WB_INSTR[31:12], WB_INSTR[6:0]};
`else
    assign unused_bits = ^{WB_INSTR[31:12], WB_INSTR[6:0], FWD_RD};
`endif

endmodule

// File: tb/tb_leve1_id.sv
// Directed, table-driven bench for leve1_id plus hand-written multi-cycle sequences.
`ifndef XLEN
`define XLEN 32
`endif

module tb_leve1_id;

    logic              clk;
    logic              rstn;
    logic              if_valid;
    logic              if_ready;
    logic [`XLEN-1:0]  if_pc;
    logic [31:0]       if_instr;
    logic              flush;
    logic [`XLEN-1:0]  fwd_rd;
    logic              wb_valid;
    logic              wb_we;
    logic [31:0]       wb_instr;
    logic [`XLEN-1:0]  wb_rd;
    logic              id_valid;
    logic [`XLEN-1:0]  id_pc;
    logic [31:0]       id_instr;
    logic [`XLEN-1:0]  id_rs1;
    logic [`XLEN-1:0]  id_rs2;

    int n_checks;
    int n_fail;

    leve1_id dut (
        .CLK      (clk),
        .RSTn     (rstn),
        .IF_VALID (if_valid),
        .IF_READY (if_ready),
        .IF_PC    (if_pc),
        .IF_INSTR (if_instr),
        .FLUSH    (flush),
        .FWD_RD   (fwd_rd),
        .WB_VALID (wb_valid),
        .WB_WE    (wb_we),
        .WB_INSTR (wb_instr),
        .WB_RD    (wb_rd),
        .ID_VALID (id_valid),
        .ID_PC    (id_pc),
        .ID_INSTR (id_instr),
        .ID_RS1   (id_rs1),
        .ID_RS2   (id_rs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              if_valid;
        logic [`XLEN-1:0]  pc;
        logic [31:0]       instr;
        logic [`XLEN-1:0]  fwd;
        logic              wb_v;
        logic              wb_we;
        logic [31:0]       wb_instr;
        logic [`XLEN-1:0]  wb_rd;
        logic              exp_ready;
        logic              exp_valid;
        logic [`XLEN-1:0]  exp_pc;
        logic [31:0]       exp_instr;
        logic              chk_rs;
        logic [`XLEN-1:0]  exp_rs1;
        logic [`XLEN-1:0]  exp_rs2;
    } vec_t;

    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [31:0] ADDI_X1_5  = 32'h0050_0093;
    localparam logic [31:0] ADD_X2_X1  = 32'h0010_8133;
    localparam logic [31:0] ADD_X3_X0  = 32'h0000_01B3;
    localparam logic [31:0] ADD_X4_X2  = 32'h0021_0233;
    localparam logic [31:0] ADD_X8_X7  = 32'h0003_8433;
    localparam logic [31:0] ADD_X10_X9 = 32'h0094_8533;
    localparam logic [31:0] CSRRW_X5   = 32'h3003_12F3;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [`XLEN-1:0] pc, input logic [31:0] ins,
                         input logic fl, input logic [`XLEN-1:0] fwd,
                         input logic wv, input logic [31:0] wi, input logic [`XLEN-1:0] wd);
        if_valid = v;  if_pc = pc;  if_instr = ins;  flush = fl;  fwd_rd = fwd;
        wb_valid = wv; wb_we = wv;  wb_instr = wi;   wb_rd = wd;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rstn     = 1'b0;
        drive(1'b1, 'h55, ADDI_X1_5, 1'b0, '0, 1'b0, 32'h0, '0);

        // Reset held two cycles with a valid fetch bundle present
        for (int c = 0; c < 2; c++) begin
            tick();
            chk($sformatf("reset%0d_valid", c), {63'd0, id_valid}, 64'd0);
            chk($sformatf("reset%0d_instr", c), {32'd0, id_instr}, {32'd0, NOP});
            chk($sformatf("reset%0d_pc", c), 64'(id_pc), 64'd0);
            chk($sformatf("reset%0d_rs1", c), 64'(id_rs1), 64'd0);
        end
        rstn = 1'b1;
        drive(1'b0, '0, 32'h0, 1'b0, '0, 1'b0, 32'h0, '0);
        #1;
        chk("reset_ready", {63'd0, if_ready}, 64'd1);

        // Main vector table, one cycle per row
        vecs[0] = '{1'b1, 32'h10, ADDI_X1_5, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b1, 1'b1, 32'h10, ADDI_X1_5, 1'b1, 32'h0, 32'h0};
        vecs[1] = '{1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h493, 32'hAAAA,
                    1'b1, 1'b0, 32'h10, NOP, 1'b0, 32'h0, 32'h0};
        vecs[2] = '{1'b1, 32'h14, ADD_X10_X9, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b1, 1'b1, 32'h14, ADD_X10_X9, 1'b1, 32'hAAAA, 32'hAAAA};
        vecs[3] = '{1'b1, 32'h18, ADD_X8_X7, 32'h0, 1'b1, 1'b1, 32'h393, 32'h1234,
                    1'b1, 1'b1, 32'h18, ADD_X8_X7, 1'b1, 32'h1234, 32'h0};
        vecs[4] = '{1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b1, 1'b0, 32'h18, NOP, 1'b0, 32'h0, 32'h0};
        vecs[5] = '{1'b1, 32'h1C, ADD_X8_X7, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b1, 1'b1, 32'h1C, ADD_X8_X7, 1'b1, 32'h1234, 32'h0};
        vecs[6] = '{1'b1, 32'h20, NOP, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b1, 1'b1, 32'h20, NOP, 1'b1, 32'h0, 32'h0};
        vecs[7] = '{1'b1, 32'h24, ADD_X3_X0, 32'h7, 1'b1, 1'b1, 32'h13, 32'hDEAD,
                    1'b1, 1'b1, 32'h24, ADD_X3_X0, 1'b1, 32'h0, 32'h0};

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].if_valid, vecs[i].pc, vecs[i].instr, 1'b0, vecs[i].fwd,
                  vecs[i].wb_v, vecs[i].wb_instr, vecs[i].wb_rd);
            wb_we = vecs[i].wb_we;
            #1;
            chk($sformatf("vec%0d_ready", i), {63'd0, if_ready}, {63'd0, vecs[i].exp_ready});
            tick();
            chk($sformatf("vec%0d_valid", i), {63'd0, id_valid}, {63'd0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_pc", i), 64'(id_pc), 64'(vecs[i].exp_pc));
            chk($sformatf("vec%0d_instr", i), {32'd0, id_instr}, {32'd0, vecs[i].exp_instr});
            if (vecs[i].chk_rs) begin
                chk($sformatf("vec%0d_rs1", i), 64'(id_rs1), 64'(vecs[i].exp_rs1));
                chk($sformatf("vec%0d_rs2", i), 64'(id_rs2), 64'(vecs[i].exp_rs2));
            end
        end

        // Dependent ALU pair: ADDI x1,x0,5 then ADD x2,x1,x1
        drive(1'b1, 'h40, ADDI_X1_5, 1'b0, '0, 1'b0, 32'h0, '0);
        tick();
        drive(1'b1, 'h44, ADD_X2_X1, 1'b0, 'h5, 1'b0, 32'h0, '0);
        #1;
`ifdef LEVE_ID_BYPASS_EN
        chk("byp_ready", {63'd0, if_ready}, 64'd1);
        tick();
        chk("byp_valid", {63'd0, id_valid}, 64'd1);
        chk("byp_rs1", 64'(id_rs1), 64'h5);
        chk("byp_rs2", 64'(id_rs2), 64'h5);
        // EX writer and WB both target x2: the younger EX result wins
        drive(1'b1, 'h48, ADD_X4_X2, 1'b0, 'h77, 1'b1, 32'h113, 'h55);
        tick();
        chk("byp_prio_rs1", 64'(id_rs1), 64'h77);
        chk("byp_prio_rs2", 64'(id_rs2), 64'h77);
`else
        chk("raw_stall_ready", {63'd0, if_ready}, 64'd0);
        tick();
        chk("raw_bubble_valid", {63'd0, id_valid}, 64'd0);
        drive(1'b1, 'h44, ADD_X2_X1, 1'b0, 'h99, 1'b1, 32'h93, 'h5);
        #1;
        chk("raw_resume_ready", {63'd0, if_ready}, 64'd1);
        tick();
        chk("raw_valid", {63'd0, id_valid}, 64'd1);
        chk("raw_pc", 64'(id_pc), 64'h44);
        chk("raw_rs1", 64'(id_rs1), 64'h5);
        chk("raw_rs2", 64'(id_rs2), 64'h5);
`endif
        drive(1'b0, '0, 32'h0, 1'b0, '0, 1'b0, 32'h0, '0);
        tick();

        // Flush kills the bundle being captured; the next bundle goes through
        drive(1'b1, 'h100, NOP, 1'b1, '0, 1'b0, 32'h0, '0);
        tick();
        chk("flush_valid", {63'd0, id_valid}, 64'd0);
        chk("flush_instr", {32'd0, id_instr}, {32'd0, NOP});
        drive(1'b1, 'h200, NOP, 1'b0, '0, 1'b0, 32'h0, '0);
        #1;
        chk("flush_ready", {63'd0, if_ready}, 64'd1);
        tick();
        chk("after_flush_valid", {63'd0, id_valid}, 64'd1);
        chk("after_flush_pc", 64'(id_pc), 64'h200);

        // CSR serialisation: exactly two not-ready cycles
        drive(1'b1, 'h300, CSRRW_X5, 1'b0, '0, 1'b0, 32'h0, '0);
        tick();
        chk("csr_valid", {63'd0, id_valid}, 64'd1);
        chk("csr_instr", {32'd0, id_instr}, {32'd0, CSRRW_X5});
        drive(1'b1, 'h304, NOP, 1'b0, '0, 1'b0, 32'h0, '0);
        #1;
        chk("csr_ser1_ready", {63'd0, if_ready}, 64'd0);
        tick();
        chk("csr_ser1_valid", {63'd0, id_valid}, 64'd0);
        chk("csr_ser2_ready", {63'd0, if_ready}, 64'd0);
        tick();
        chk("csr_ser2_valid", {63'd0, id_valid}, 64'd0);
        chk("csr_run_ready", {63'd0, if_ready}, 64'd1);
        tick();
        chk("csr_run_valid", {63'd0, id_valid}, 64'd1);
        chk("csr_run_pc", 64'(id_pc), 64'h304);

        // FLUSH while in SER1 returns straight to RUN
        drive(1'b1, 'h400, CSRRW_X5, 1'b0, '0, 1'b0, 32'h0, '0);
        tick();
        drive(1'b1, 'h404, NOP, 1'b1, '0, 1'b0, 32'h0, '0);
        #1;
        chk("ser1_flush_pre_ready", {63'd0, if_ready}, 64'd0);
        tick();
        chk("ser1_flush_valid", {63'd0, id_valid}, 64'd0);
        chk("ser1_flush_ready", {63'd0, if_ready}, 64'd1);
        drive(1'b1, 'h408, NOP, 1'b0, '0, 1'b0, 32'h0, '0);
        tick();
        chk("ser1_flush_cap_valid", {63'd0, id_valid}, 64'd1);
        chk("ser1_flush_cap_pc", 64'(id_pc), 64'h408);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
